// File: rtl/seq101_frame_ctrl.sv
// seq101_frame_ctrl: loads a frame of up to DATA_W bits, shifts it MSB first
// through a Moore "101" detector, and reports the overlapping hit count.
// Optional feature: define SEQ101_FRAME_CTRL_ABORT_EN to add abort/aborted ports.
module seq101_frame_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] data_in,
`ifdef SEQ101_FRAME_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              det_bit,
  output logic              det_hit
);

  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned ELEN_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DET_ZERO       = 2'd0,
    DET_ONE        = 2'd1,
    DET_ONEZERO    = 2'd2,
    DET_ONEZEROONE = 2'd3
  } det_e;

  state_e              state_q, state_d;
  det_e                det_q, det_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                det_bit_q, det_bit_d;
  logic                det_hit_q, det_hit_d;
  logic                det_clr;
  logic                aborted_q, aborted_d;
  logic                abort_req;

  logic [ELEN_W-1:0]   eff_len_c;
  logic [IDX_W-1:0]    first_idx_c;
  logic [CNT_W-1:0]    cnt_sat_c;
  logic                hit_cnt_c;

`ifdef SEQ101_FRAME_CTRL_ABORT_EN
  assign abort_req = abort;
  assign aborted   = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // Effective frame length: zero or oversize requests fall back to DATA_W
  always_comb begin
    eff_len_c = ELEN_W'(DATA_W);
    if ((frame_len != '0) && (32'(frame_len) <= DATA_W)) begin
      eff_len_c = ELEN_W'(frame_len);
    end
    first_idx_c = IDX_W'(eff_len_c - ELEN_W'(1));
  end

  // Saturating hit counter increment, counted only while a frame is in flight
  always_comb begin
    cnt_sat_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    hit_cnt_c = det_hit_q && ((state_q == ST_SHIFT) || (state_q == ST_FLUSH));
  end

  // Frame FSM next-state and datapath
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    match_cnt_d = match_cnt_q;
    det_bit_d   = 1'b0;
    det_clr     = 1'b0;
    aborted_d   = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d    = data_in;
          idx_d     = first_idx_c;
          det_bit_d = data_in[first_idx_c];
          cnt_d     = '0;
          det_clr   = 1'b1;
          aborted_d = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (hit_cnt_c) begin
          cnt_d = cnt_sat_c;
        end
        if (abort_req) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (idx_q == '0) begin
          state_d = ST_FLUSH;
        end else begin
          idx_d     = idx_q - IDX_W'(1);
          det_bit_d = data_q[idx_d];
        end
      end
      ST_FLUSH: begin
        if (hit_cnt_c) begin
          cnt_d = cnt_sat_c;
        end
        if (abort_req) begin
          aborted_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_DONE) begin
      match_cnt_d = cnt_d;
    end
  end

  // Moore "101" detector fed by the registered serial bit
  always_comb begin
    det_d = det_q;
    if (det_clr) begin
      det_d = DET_ZERO;
    end else begin
      case (det_q)
        DET_ZERO:       det_d = det_bit_q ? DET_ONE        : DET_ZERO;
        DET_ONE:        det_d = det_bit_q ? DET_ONE        : DET_ONEZERO;
        DET_ONEZERO:    det_d = det_bit_q ? DET_ONEZEROONE : DET_ZERO;
        DET_ONEZEROONE: det_d = det_bit_q ? DET_ONE        : DET_ONEZERO;
        default:        det_d = DET_ZERO;
      endcase
    end
    det_hit_d = (det_d == DET_ONEZEROONE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      det_q       <= DET_ZERO;
      data_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_bit_q   <= 1'b0;
      det_hit_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      det_bit_q   <= det_bit_d;
      det_hit_q   <= det_hit_d;
      aborted_q   <= aborted_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = match_cnt_q;
  assign det_bit   = det_bit_q;
  assign det_hit   = det_hit_q;

endmodule
